// File: rtl/rr_x_in_pkg.sv
// Shared constants and helpers for the rr_x_in arbiter family.
package rr_x_in_pkg;

    // Ceiling log2, for deriving index widths from source counts.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Exactly one bit set; callers zero-extend narrower vectors.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    localparam int unsigned IO_SIZE_DEF = 5;
    localparam int unsigned IO_W_DEF    = clog2(IO_SIZE_DEF);
    localparam int unsigned CNT_W_DEF   = 2;

endpackage

// File: rtl/req_grant_tracker_if.sv
// Request/grant bundle between the sources/arbiter side and the tracker.
interface req_grant_tracker_if
    import rr_x_in_pkg::*;
#(
    parameter int unsigned IO_SIZE = IO_SIZE_DEF,
    parameter int unsigned IO_w    = IO_W_DEF
);
    logic [IO_SIZE-1:0] req_pulse_in;
    logic [IO_SIZE-1:0] req_vector_out;
    logic [IO_SIZE-1:0] grant_in;
    logic               grant_valid_out;
    logic [IO_w-1:0]    grant_idx_out;
    logic               clr_err_in;
    logic               grant_err_out;
    logic [IO_SIZE-1:0] ovf_out;

    modport slave (
        input  req_pulse_in, grant_in, clr_err_in,
        output req_vector_out, grant_valid_out, grant_idx_out, grant_err_out, ovf_out
    );

    modport master (
        output req_pulse_in, grant_in, clr_err_in,
        input  req_vector_out, grant_valid_out, grant_idx_out, grant_err_out, ovf_out
    );
endinterface

// File: rtl/onehot_enc_x_in.sv
// Combinational one-hot to binary encoder; all-zero input encodes to 0.
module onehot_enc_x_in
    import rr_x_in_pkg::*;
#(
    parameter int unsigned IO_SIZE = IO_SIZE_DEF,
    parameter int unsigned IO_w    = IO_W_DEF
) (
    input  logic [IO_SIZE-1:0] i_onehot,
    output logic [IO_w-1:0]    o_idx
);

    // OR together the indices of all set bits (exact for one-hot input).
    always_comb begin
        o_idx = '0;
        for (int unsigned j = 0; j < IO_SIZE; j++) begin
            if (i_onehot[j]) begin
                o_idx = o_idx | IO_w'(j);
            end
        end
    end

endmodule

// File: rtl/req_grant_tracker.sv
// Per-source pending-request counters feeding an arbiter; retires one
// request per valid grant and flags protocol violations and overflows.
module req_grant_tracker
    import rr_x_in_pkg::*;
#(
    parameter int unsigned IO_SIZE = IO_SIZE_DEF,
    parameter int unsigned IO_w    = IO_W_DEF,
    parameter int unsigned CNT_w   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    req_grant_tracker_if.slave bus
);

    localparam logic [CNT_w-1:0] CNT_MAX = '1;

    logic [CNT_w-1:0]   r_cnt   [IO_SIZE];
    logic [CNT_w-1:0]   w_cnt_d [IO_SIZE];
    logic [IO_SIZE-1:0] w_pend;
    logic [IO_SIZE-1:0] w_dec;
    logic [IO_SIZE-1:0] w_ovf_set;
    logic [IO_w-1:0]    w_enc_idx;
    logic               w_onehot;
    logic               w_valid;
    logic               w_err_set;

    logic               r_grant_valid;
    logic [IO_w-1:0]    r_grant_idx;
    logic               r_grant_err;
    logic [IO_SIZE-1:0] r_ovf;

    // A grant is honoured only if one-hot and aimed at a pending source.
    assign w_onehot  = is_onehot(32'(bus.grant_in));
    assign w_valid   = w_onehot && ((bus.grant_in & w_pend) != '0);
    assign w_err_set = (bus.grant_in != '0) && !w_valid;
    assign w_dec     = w_valid ? bus.grant_in : '0;

    onehot_enc_x_in #(
        .IO_SIZE (IO_SIZE),
        .IO_w    (IO_w)
    ) u_enc (
        .i_onehot (bus.grant_in),
        .o_idx    (w_enc_idx)
    );

    for (genvar j = 0; j < IO_SIZE; j++) begin : g_src
        logic w_inc;
        logic w_full;
        assign w_inc        = bus.req_pulse_in[j];
        assign w_full       = (r_cnt[j] == CNT_MAX);
        assign w_pend[j]    = (r_cnt[j] != '0);
        // Simultaneous post and retire cancel, even at full.
        assign w_ovf_set[j] = w_inc && !w_dec[j] && w_full;
        assign w_cnt_d[j]   = (w_inc && !w_dec[j] && !w_full) ? r_cnt[j] + 1'b1 :
                              (w_dec[j] && !w_inc)            ? r_cnt[j] - 1'b1 :
                                                                r_cnt[j];
    end

    // Pending-request counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < IO_SIZE; j++) begin
                r_cnt[j] <= '0;
            end
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    // Registered grant report; index holds when no valid grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
        end else begin
            r_grant_valid <= w_valid;
            if (w_valid) begin
                r_grant_idx <= w_enc_idx;
            end
        end
    end

    // Sticky flags; a set event in the clear cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_err <= 1'b0;
            r_ovf       <= '0;
        end else begin
            r_grant_err <= (r_grant_err && !bus.clr_err_in) || w_err_set;
            r_ovf       <= (r_ovf & {IO_SIZE{!bus.clr_err_in}}) | w_ovf_set;
        end
    end

    assign bus.req_vector_out  = w_pend;
    assign bus.grant_valid_out = r_grant_valid;
    assign bus.grant_idx_out   = r_grant_idx;
    assign bus.grant_err_out   = r_grant_err;
    assign bus.ovf_out         = r_ovf;

endmodule

// File: tb/tb_req_grant_tracker.sv
// Directed vector table, async-reset sequence and random stress against a
// fixed-priority arbiter model for req_grant_tracker.
module tb_req_grant_tracker;

    typedef struct {
        logic [4:0] pulse;
        logic [4:0] grant;
        logic       clr;
        logic [4:0] req;
        logic       gv;
        logic [2:0] gi;
        logic       err;
        logic [4:0] ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    req_grant_tracker_if #(.IO_SIZE(5), .IO_w(3)) bus ();

    req_grant_tracker #(.IO_SIZE(5), .IO_w(3), .CNT_w(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [4:0] p, input logic [4:0] g, input logic c,
                       input logic [4:0] r, input logic v, input logic [2:0] i,
                       input logic e, input logic [4:0] o);
        vec_t t;
        t.pulse = p; t.grant = g; t.clr = c;
        t.req = r; t.gv = v; t.gi = i; t.err = e; t.ovf = o;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic [4:0] p, input logic [4:0] g, input logic c);
        bus.req_pulse_in = p;
        bus.grant_in     = g;
        bus.clr_err_in   = c;
    endtask

    task automatic chk_all(input string tag, input logic [4:0] r, input logic v,
                           input logic [2:0] i, input logic e, input logic [4:0] o);
        chk({tag, " req"}, 32'(bus.req_vector_out), 32'(r));
        chk({tag, " gvalid"}, 32'(bus.grant_valid_out), 32'(v));
        chk({tag, " gidx"}, 32'(bus.grant_idx_out), 32'(i));
        chk({tag, " err"}, 32'(bus.grant_err_out), 32'(e));
        chk({tag, " ovf"}, 32'(bus.ovf_out), 32'(o));
    endtask

    initial begin
        logic [1:0] mcnt [5];
        logic [4:0] movf;
        logic [4:0] p;
        logic [4:0] g;
        logic [4:0] mreq;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(5'b0, 5'b0, 1'b0);

        //          pulse    grant    clr   req      gv  gi    err  ovf
        add(5'b00100, 5'b00000, 0, 5'b00100, 0, 3'd0, 0, 5'b00000); // post src2
        add(5'b00000, 5'b00100, 0, 5'b00000, 1, 3'd2, 0, 5'b00000); // grant src2
        add(5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd2, 0, 5'b00000); // idx holds
        add(5'b00001, 5'b00000, 0, 5'b00001, 0, 3'd2, 0, 5'b00000); // src0 -> 1
        add(5'b00001, 5'b00000, 0, 5'b00001, 0, 3'd2, 0, 5'b00000); // src0 -> 2
        add(5'b00001, 5'b00000, 0, 5'b00001, 0, 3'd2, 0, 5'b00000); // src0 -> 3
        add(5'b00001, 5'b00000, 0, 5'b00001, 0, 3'd2, 0, 5'b00001); // overflow
        add(5'b00000, 5'b00001, 0, 5'b00001, 1, 3'd0, 0, 5'b00001); // 3 -> 2
        add(5'b00000, 5'b00001, 0, 5'b00001, 1, 3'd0, 0, 5'b00001); // 2 -> 1
        add(5'b00000, 5'b00001, 0, 5'b00000, 1, 3'd0, 0, 5'b00001); // 1 -> 0
        add(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd0, 0, 5'b00000); // clear ovf
        add(5'b10000, 5'b00000, 0, 5'b10000, 0, 3'd0, 0, 5'b00000); // src4 -> 1
        add(5'b10000, 5'b00000, 0, 5'b10000, 0, 3'd0, 0, 5'b00000); // src4 -> 2
        add(5'b10000, 5'b00000, 0, 5'b10000, 0, 3'd0, 0, 5'b00000); // src4 -> 3
        add(5'b10000, 5'b10000, 0, 5'b10000, 1, 3'd4, 0, 5'b00000); // inc+dec at max
        add(5'b10000, 5'b00000, 0, 5'b10000, 0, 3'd4, 0, 5'b10000); // overflow src4
        add(5'b10000, 5'b00000, 1, 5'b10000, 0, 3'd4, 0, 5'b10000); // set beats clr
        add(5'b00000, 5'b00000, 1, 5'b10000, 0, 3'd4, 0, 5'b00000); // clear
        add(5'b00011, 5'b00000, 0, 5'b10011, 0, 3'd4, 0, 5'b00000); // src0,1 -> 1
        add(5'b00000, 5'b00011, 0, 5'b10011, 0, 3'd4, 1, 5'b00000); // multi-hot
        add(5'b00000, 5'b00000, 1, 5'b10011, 0, 3'd4, 0, 5'b00000); // clear err
        add(5'b00000, 5'b00100, 0, 5'b10011, 0, 3'd4, 1, 5'b00000); // idle grant
        add(5'b00000, 5'b01000, 1, 5'b10011, 0, 3'd4, 1, 5'b00000); // set beats clr
        add(5'b00000, 5'b00000, 1, 5'b10011, 0, 3'd4, 0, 5'b00000); // clear err
        add(5'b00000, 5'b00010, 0, 5'b10001, 1, 3'd1, 0, 5'b00000); // grant src1
        add(5'b00000, 5'b10000, 0, 5'b10001, 1, 3'd4, 0, 5'b00000); // src4 3 -> 2

        #2;
        chk_all("reset", 5'b0, 1'b0, 3'd0, 1'b0, 5'b0);
        #10 rst = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].pulse, vecs[k].grant, vecs[k].clr);
            tick();
            chk_all($sformatf("row%0d", k), vecs[k].req, vecs[k].gv, vecs[k].gi,
                    vecs[k].err, vecs[k].ovf);
        end
        drive(5'b0, 5'b0, 1'b0);

        // Async reset between edges with src0 and src4 pending.
        #1 rst = 1'b1;
        #1 chk_all("async_rst", 5'b0, 1'b0, 3'd0, 1'b0, 5'b0);
        #3 rst = 1'b0;

        drive(5'b00100, 5'b0, 1'b0);
        tick();
        chk("post_rst req", 32'(bus.req_vector_out), 32'h04);
        drive(5'b0, 5'b00100, 1'b0);
        tick();
        chk("post_rst gvalid", 32'(bus.grant_valid_out), 32'h1);
        chk("post_rst gidx", 32'(bus.grant_idx_out), 32'h2);
        drive(5'b0, 5'b0, 1'b0);
        tick();
        chk("post_rst req_drop", 32'(bus.req_vector_out), 32'h0);

        // Random stress with a lowest-index-first arbiter in the loop.
        for (int j = 0; j < 5; j++) mcnt[j] = 2'd0;
        movf = 5'b0;
        for (int c = 0; c < 10000; c++) begin
            p = 5'($urandom_range(0, 31));
            g = 5'b0;
            if ($urandom_range(0, 3) != 0) begin
                for (int j = 4; j >= 0; j--) begin
                    if (bus.req_vector_out[j]) g = 5'(1 << j);
                end
            end
            for (int j = 0; j < 5; j++) begin
                if (p[j] && !(g[j] && mcnt[j] != 2'd0)) begin
                    if (mcnt[j] == 2'd3) movf[j] = 1'b1;
                    else mcnt[j] = mcnt[j] + 2'd1;
                end else if (!p[j] && g[j] && mcnt[j] != 2'd0) begin
                    mcnt[j] = mcnt[j] - 2'd1;
                end
            end
            for (int j = 0; j < 5; j++) mreq[j] = (mcnt[j] != 2'd0);
            drive(p, g, 1'b0);
            tick();
            chk($sformatf("stress%0d req", c), 32'(bus.req_vector_out), 32'(mreq));
            chk($sformatf("stress%0d gvalid", c), 32'(bus.grant_valid_out), 32'(g != 5'b0));
        end
        drive(5'b0, 5'b0, 1'b0);
        chk("stress err", 32'(bus.grant_err_out), 32'h0);
        chk("stress ovf", 32'(bus.ovf_out), 32'(movf));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/req_grant_tracker.md
Name: req_grant_tracker

Overview:
- Requester-side companion of the fixed-priority/round-robin arbiters in the rr_x_in family.
- Accumulates request events from IO_SIZE sources in per-source pending counters and presents a level request vector to the arbiter.
- Consumes the arbiter's one-hot grant, retires one pending request per grant, and returns a registered binary grant index to the sources.
- Checks the grant for protocol violations.

Parameters:
- IO_SIZE, 5, number of requesting sources (arbiter width).
- IO_w, 3, width of binary grant index; must satisfy 2^IO_w >= IO_SIZE.
- CNT_w, 2, width of per-source pending counter; max outstanding per source = 2^CNT_w - 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_pulse_in  in  IO_SIZE  bit j = 1 for one cycle: source j posts one new request.
- req_vector_out  out  IO_SIZE  to arbiter; bit j = (cnt[j] != 0), driven directly from counter registers.
- grant_in  in  IO_SIZE  one-hot grant from arbiter; combinational function of req_vector_out, sampled same cycle.
- grant_valid_out  out  1  registered; one valid grant was accepted in the previous cycle.
- grant_idx_out  out  IO_w  registered binary index of that grant; holds last value when grant_valid_out = 0.
- clr_err_in  in  1  synchronous clear of sticky error/overflow flags.
- grant_err_out  out  1  sticky protocol-violation flag.
- ovf_out  out  IO_SIZE  sticky per-source overflow flag.

Behaviour:
- Reset (async assert, sync-safe deassert): cnt[*] = 0, req_vector_out = 0, grant_valid_out = 0, grant_idx_out = 0, grant_err_out = 0, ovf_out = 0.
- Valid grant: grant_in is exactly one-hot and the granted bit j has cnt[j] != 0.
- Grant of all zeros: no action, no error.
- Multi-hot grant, or one-hot grant to a source with cnt = 0:
  - No counter is decremented.
  - grant_valid_out = 0 next cycle.
  - grant_err_out set next cycle.
- Per source j, each cycle, with dec = (valid grant to j) and inc = req_pulse_in[j]:
  - inc & dec: cnt unchanged. Legal even when cnt is at max; no overflow.
  - inc only, cnt < max: cnt + 1.
  - inc only, cnt = max: pulse dropped, cnt stays at max, ovf_out[j] set.
  - dec only: cnt - 1.
  - Counters never wrap in either direction.
- Latency:
  - req_pulse_in to req_vector_out: 1 cycle.
  - grant_in to grant_valid_out / grant_idx_out: 1 cycle.
  - grant to counter decrement visible on req_vector_out: 1 cycle, so a source with cnt = 1 drops its request the cycle after its grant.
- Back-to-back grants to the same source are allowed every cycle while cnt > 0.
- Sticky flags:
  - clr_err_in clears grant_err_out and all ovf_out bits.
  - A new set event in the same cycle as clr_err_in wins; the flag reads 1.
- No internal FSM beyond the counters. All outputs are registered except req_vector_out, which is decoded directly from registers (no combinational path from inputs).

Decomposition:
- Shared package (rr_x_in_pkg):
  - Default IO_SIZE / IO_w constants.
  - Function is_onehot(vector) -> 1 bit.
  - Function clog2 for deriving IO_w.
- Sub-module onehot_enc_x_in: purely combinational IO_SIZE one-hot to IO_w binary encoder, output 0 for all-zero input. Instantiated once on grant_in; its output is registered in this block.
- Per-source counter logic is a generate loop; not a separate module.

Test Plan:
- Reset, then pulse source 2 once: req_vector_out = 5'b00100 one cycle later. grant_in = 5'b00100 -> next cycle grant_valid_out = 1, grant_idx_out = 2; the cycle after, req_vector_out = 0.
- Overflow (CNT_w = 2): pulse source 0 four consecutive cycles, no grant -> cnt[0] saturates at 3, ovf_out[0] = 1. Three grants to bit 0 -> req_vector_out[0] returns to 0 after the third.
- Simultaneous events: source 4 at cnt = 3 gets a pulse and a grant in the same cycle -> cnt stays 3, ovf_out[4] stays 0, grant_valid_out = 1, grant_idx_out = 4.
- Protocol errors:
  - grant_in = 5'b00011 with both sources pending -> no decrement, grant_valid_out = 0, grant_err_out = 1.
  - grant to an idle source -> grant_err_out = 1.
  - clr_err_in pulse -> grant_err_out = 0 next cycle.
- Async reset mid-operation: assert rst between clock edges with several counters non-zero -> all outputs 0 immediately, without waiting for a clock edge. After deassert, a fresh pulse behaves as in scenario 1.
- Random stress against the FPA_X_IN arbiter in loop, 10k cycles: scoreboard (pulses accepted) - (grants) = sum of counters at every cycle; grant_err_out never set.
